// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Shares one 8-bit ALU between NREQ requesters. Each requester
//               uses a valid/ready request handshake and gets a one-cycle
//               response strobe. Arbitration is round-robin. MUL/DIV get
//               EXT_LAT extra execute cycles. Divide-by-zero returns a
//               defined result.
// Config      : define ALU_ARB_FIXED_PRIO_EN for fixed priority, where the
//               lowest requester index always wins and the pointer stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
  parameter int NREQ    = 4,
  parameter int EXT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_cout,
  output logic              rsp_of,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_op,
  input  logic [7:0]        alu_out,
  input  logic              alu_cout,
  input  logic              alu_of,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (EXT_LAT > 0) ? $clog2(EXT_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [3:0]      op_q, op_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      res_q, res_d;
  logic            cout_q, cout_d;
  logic            of_q, of_d;

  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [3:0]      win_op;

  // Search requesters starting at the pointer; the descending loop lets the
  // nearest valid requester (smallest offset) overwrite farther ones.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [PW:0] cand;
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (req_valid[cand[PW-1:0]]) begin
        win_idx   = cand[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign win_op = req_op[4*int'(win_idx) +: 4];

  // Next-state logic: grant and latch in IDLE, count/capture in EXEC,
  // advance the pointer past the owner in RESP.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    cout_d    = cout_q;
    of_d      = of_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          owner_d = win_idx;
          op_d    = win_op;
          a_d     = req_a[8*int'(win_idx) +: 8];
          b_d     = req_b[8*int'(win_idx) +: 8];
          cnt_d   = ((win_op == 4'd5) || (win_op == 4'd6)) ? CW'(EXT_LAT) : '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if ((op_q == 4'd6) && (b_q == 8'h00)) begin
            res_d  = 8'hFF;
            cout_d = 1'b0;
            of_d   = 1'b1;
          end else begin
            res_d  = alu_out;
            cout_d = alu_cout;
            of_d   = alu_of;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and result registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      of_q    <= of_d;
    end
  end

  // One-cycle response strobe to the owner while in RESP.
  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign rsp_data = res_q;
  assign rsp_cout = cout_q;
  assign rsp_of   = of_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Scoreboard bench for alu_share_arb with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

  localparam int NREQ    = 4;
  localparam int EXT_LAT = 2;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_cout;
  logic              rsp_of;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [3:0]        alu_op;
  logic [7:0]        alu_out;
  logic              alu_cout;
  logic              alu_of;
  logic              busy;

  typedef struct {
    int         owner;
    logic [7:0] data;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  alu_share_arb #(.NREQ(NREQ), .EXT_LAT(EXT_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_of    (rsp_of),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .alu_of    (alu_of),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: 1 ADD, 5 MUL (low byte), 6 DIV, everything else 0.
  always_comb begin
    logic [15:0] prod;
    alu_out  = 8'h00;
    alu_cout = 1'b0;
    alu_of   = 1'b0;
    prod     = 16'(alu_a) * 16'(alu_b);
    case (alu_op)
      4'd1: begin
        {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_of = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
      end
      4'd5: alu_out = prod[7:0];
      4'd6: if (alu_b != 8'h00) alu_out = alu_a / alu_b;
      default: alu_out = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every response strobe.
  always @(negedge clk) begin
    if (reset_n && (rsp_valid != '0)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual rsp_valid=%b required none", rsp_valid);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_owner", 32'(rsp_valid), 32'(1) << mon_e.owner);
        check("rsp_data",  32'(rsp_data),  32'(mon_e.data));
        check("rsp_cout",  32'(rsp_cout),  32'(mon_e.cout));
        check("rsp_of",    32'(rsp_of),    32'(mon_e.ovf));
        check("rsp_cycle", 32'(cyc),       32'(mon_e.cyc));
      end
    end
  end

  // Wait (bounded) for any grant; returns index and cycle of the grant cycle.
  task automatic wait_grant(output int gidx, output int gcyc);
    gidx = -1;
    gcyc = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx = i;
        gcyc = cyc;
        break;
      end
    end
    if (gidx < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual none required a grant");
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[4*idx +: 4] = op;
    req_a[8*idx +: 8]  = a;
    req_b[8*idx +: 8]  = b;
  endtask

  task automatic issue(input int idx, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic ec, input logic eo, input int wt);
    int g, c;
    set_req(idx, op, a, b);
    req_valid[idx] = 1'b1;
    wait_grant(g, c);
    check("grant_idx", 32'(g), 32'(idx));
    sbq.push_back('{idx, ed, ec, eo, c + 2 + wt});
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    set_req(idx, 4'hA, 8'h55, 8'hAA);
    repeat (wt + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    int g, c, prev;
    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    prev      = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 4'd1, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 0);
    check("rsp_data_hold", 32'(rsp_data), 32'h10);
    check("idle_busy", 32'(busy), 32'd0);
    issue(1, 4'd5, 8'h05, 8'h03, 8'h0F, 1'b0, 1'b0, EXT_LAT);
    issue(2, 4'd6, 8'h40, 8'h00, 8'hFF, 1'b0, 1'b1, EXT_LAT);

    // Reset in the middle of an EXEC for requester 3.
    set_req(3, 4'd1, 8'h33, 8'h44);
    req_valid[3] = 1'b1;
    wait_grant(g, c);
    check("r3_grant", 32'(g), 32'd3);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    check("exec_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",  32'(busy),   32'd0);
    check("mid_rst_alu_a", 32'(alu_a),  32'd0);
    check("mid_rst_alu_op",32'(alu_op), 32'd0);
    check("mid_rst_data",  32'(rsp_data), 32'd0);
    check("mid_rst_of",    32'(rsp_of),   32'd0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    set_req(1, 4'd1, 8'h7F, 8'h01);
    set_req(3, 4'd1, 8'h01, 8'h01);
    req_valid = 4'b1010;
    wait_grant(g, c);
    check("post_rst_grant", 32'(g), 32'd1);
    sbq.push_back('{1, 8'h80, 1'b0, 1'b1, c + 2});
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;

    // Fresh pointer for the arbitration-order test.
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'd1, 8'(i + 1), 8'h10);
`ifdef ALU_ARB_FIXED_PRIO_EN
    req_valid = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      wait_grant(g, c);
      check("fp_grant", 32'(g), 32'd0);
      sbq.push_back('{0, 8'h11, 1'b0, 1'b0, c + 2});
      @(posedge clk);
      #1;
    end
`else
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, c);
      check("rr_grant", 32'(g), 32'(n % 4));
      if (n > 0) check("rr_spacing", 32'(c - prev), 32'd3);
      prev = c;
      sbq.push_back('{n % 4, 8'(8'h11 + n % 4), 1'b0, 1'b0, c + 2});
      @(posedge clk);
      #1;
    end
`endif
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
